// File: rtl/execute_mul.sv
// Y86-64 execute stage: ALU plus iterative shift-add MULQ. It also owns the condition codes.
// ALU ops are single-cycle. MULQ holds e_stall_o high for XLEN+1 cycles, and its product appears in the following cycle.
module execute_mul #(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [3:0]      E_icode_i,
  input  logic [3:0]      E_ifun_i,
  input  logic [XLEN-1:0] E_valC_i,
  input  logic [XLEN-1:0] E_valA_i,
  input  logic [XLEN-1:0] E_valB_i,
  input  logic [3:0]      E_dstE_i,
  input  logic [3:0]      E_dstM_i,
  input  logic [2:0]      m_stat_i,
  input  logic [2:0]      W_stat_i,
  output logic            e_Cnd_o,
  output logic [XLEN-1:0] e_valE_o,
  output logic [3:0]      e_dstE_o,
  output logic [3:0]      e_dstM_o,
  output logic            e_stall_o
);
  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ = 4'h6, I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_XOR = 4'h3, A_MUL = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [2:0] SADR = 3'd2, SINS = 3'd3, SHLT = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_acc, r_mcand, r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_cc;  // {ZF, SF, OF}

  logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_res, w_val_e;
  logic [3:0]      w_alu_fun;
  logic [2:0]      w_new_cc;
  logic            w_is_op, w_is_mul, w_exc, w_of, w_cnd;
  logic            w_stall, w_start, w_step, w_cc_we;

  assign w_is_op   = (E_icode_i == I_OPQ);
  assign w_is_mul  = w_is_op && (E_ifun_i == A_MUL) && MUL_EN;
  assign w_alu_fun = (w_is_op && !((E_ifun_i == A_MUL) && !MUL_EN)) ? E_ifun_i : A_ADD;
  assign w_exc     = (m_stat_i inside {SADR, SINS, SHLT}) || (W_stat_i inside {SADR, SINS, SHLT});

  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    case (E_icode_i)
      I_RRMOVQ:           w_alu_a = E_valA_i;
      I_OPQ:              begin w_alu_a = E_valA_i; w_alu_b = E_valB_i; end
      I_IRMOVQ:           w_alu_a = E_valC_i;
      I_RMMOVQ, I_MRMOVQ: begin w_alu_a = E_valC_i; w_alu_b = E_valB_i; end
      I_CALL, I_PUSHQ:    begin w_alu_a = ~XLEN'(7); w_alu_b = E_valB_i; end
      I_RET, I_POPQ:      begin w_alu_a = XLEN'(8);  w_alu_b = E_valB_i; end
      default:            ;
    endcase
  end

  // MUL falls to the default arm, so OF reads 0 when the product is presented.
  always_comb begin
    w_alu_res = '0;
    w_of      = 1'b0;
    case (w_alu_fun)
      A_ADD: begin
        w_alu_res = w_alu_b + w_alu_a;
        w_of = (w_alu_a[XLEN-1] == w_alu_b[XLEN-1]) && (w_alu_res[XLEN-1] != w_alu_b[XLEN-1]);
      end
      A_SUB: begin
        w_alu_res = w_alu_b - w_alu_a;
        w_of = (w_alu_a[XLEN-1] != w_alu_b[XLEN-1]) && (w_alu_res[XLEN-1] != w_alu_b[XLEN-1]);
      end
      A_AND:   w_alu_res = w_alu_b & w_alu_a;
      A_XOR:   w_alu_res = w_alu_b ^ w_alu_a;
      default: ;
    endcase
  end

  assign w_val_e  = (r_state == S_DONE) ? r_acc : w_alu_res;
  assign w_new_cc = {(w_val_e == '0), w_val_e[XLEN-1], w_of};

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_cc_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mul && !w_exc) begin
          w_stall     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = S_MUL;
        end else if (w_is_op && !w_exc && !w_is_mul) begin
          w_cc_we = 1'b1;
        end
      end
      S_MUL: begin
        if (w_exc) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_stall = 1'b1;
          w_step  = 1'b1;
          if (r_cnt == '0) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cc_we     = w_is_op && !w_exc;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnd = 1'b0;
    case (E_ifun_i)
      4'h0: w_cnd = 1'b1;
      4'h1: w_cnd = (r_cc[1] ^ r_cc[0]) | r_cc[2];
      4'h2: w_cnd = r_cc[1] ^ r_cc[0];
      4'h3: w_cnd = r_cc[2];
      4'h4: w_cnd = ~r_cc[2];
      4'h5: w_cnd = ~(r_cc[1] ^ r_cc[0]);
      4'h6: w_cnd = ~(r_cc[1] ^ r_cc[0]) & ~r_cc[2];
      default: w_cnd = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_cc     <= 3'b100;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cc_we) r_cc <= w_new_cc;
      if (w_start) begin
        r_acc    <= '0;
        r_mcand  <= E_valB_i;
        r_mplier <= E_valA_i;
        r_cnt    <= CW'(XLEN - 1);
      end else if (w_step) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
      end
    end
  end

  // Gated by reset so the stall drops the moment reset asserts, not at the next edge.
  assign e_stall_o = w_stall & rst_n_i;
  assign e_valE_o  = w_val_e;
  assign e_Cnd_o   = w_cnd;
  assign e_dstE_o  = ((E_icode_i == I_RRMOVQ) && !w_cnd) ? RNONE : E_dstE_i;
  assign e_dstM_o  = E_dstM_i;
endmodule

// File: tb/tb_execute_mul.sv
// Bench for execute_mul: a randomized ALU/cmov sweep and the MULQ timing scenarios on 64-bit and 16-bit instances.
module tb_execute_mul;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  icode, ifun, dstE, dstM;
  logic [63:0] valA, valB, valC;
  logic [2:0]  m_stat, W_stat;
  logic        cnd, stall, cnd16, stall16;
  logic [63:0] valE;
  logic [15:0] valE16;
  logic [3:0]  oDstE, oDstM, oDstE16, oDstM16;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [2:0]  m_cc;

  execute_mul #(.XLEN(64), .MUL_EN(1'b1)) u_dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .E_icode_i(icode), .E_ifun_i(ifun),
    .E_valC_i(valC), .E_valA_i(valA), .E_valB_i(valB), .E_dstE_i(dstE), .E_dstM_i(dstM),
    .m_stat_i(m_stat), .W_stat_i(W_stat), .e_Cnd_o(cnd), .e_valE_o(valE),
    .e_dstE_o(oDstE), .e_dstM_o(oDstM), .e_stall_o(stall));

  execute_mul #(.XLEN(16), .MUL_EN(1'b1)) u_dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .E_icode_i(icode), .E_ifun_i(ifun),
    .E_valC_i(valC[15:0]), .E_valA_i(valA[15:0]), .E_valB_i(valB[15:0]), .E_dstE_i(dstE),
    .E_dstM_i(dstM), .m_stat_i(m_stat), .W_stat_i(W_stat), .e_Cnd_o(cnd16),
    .e_valE_o(valE16), .e_dstE_o(oDstE16), .e_dstM_o(oDstM16), .e_stall_o(stall16));

  // Reference model: the Y86 execute rules computed directly with plain arithmetic.
  function automatic logic [63:0] ref_valE(logic [3:0] ic, logic [3:0] fn,
                                           logic [63:0] a, logic [63:0] b, logic [63:0] c);
    case (ic)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h6: case (fn)
              4'h0: return b + a;
              4'h1: return b - a;
              4'h2: return b & a;
              4'h3: return b ^ a;
              4'h4: return b * a;
              default: return 64'd0;
            endcase
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_cc(logic [3:0] fn, logic [63:0] a, logic [63:0] b, logic [63:0] r);
    logic of;
    of = 1'b0;
    if (fn == 4'h0) of = (a[63] == b[63]) && (r[63] != b[63]);
    if (fn == 4'h1) of = (a[63] != b[63]) && (r[63] != b[63]);
    return {(r == 64'd0), r[63], of};
  endfunction

  function automatic logic ref_cnd(logic [3:0] fn, logic [2:0] cc);
    logic zf, lt;
    zf = cc[2];
    lt = cc[1] ^ cc[0];
    case (fn)
      4'h0: return 1'b1;
      4'h1: return lt || zf;
      4'h2: return lt;
      4'h3: return zf;
      4'h4: return !zf;
      4'h5: return !lt;
      4'h6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(logic [3:0] ic, logic [3:0] fn, logic [63:0] a, logic [63:0] b);
    icode = ic; ifun = fn; valA = a; valB = b;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_op(4'h6, 4'h4, 64'd7, 64'd6);
    valC = 64'd0; dstE = 4'h3; dstM = 4'h5; m_stat = 3'd1; W_stat = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (u_dut64.r_cc !== 3'b100) begin n_bad++; $display("FAIL reset_cc: got %b want 100", u_dut64.r_cc); end
    icode = 4'h2; ifun = 4'h3; #1;
    n_cmp++; if (cnd !== 1'b1) begin n_bad++; $display("FAIL reset_cmove: got %b want 1", cnd); end
    ifun = 4'h2; #1;
    n_cmp++; if (oDstE !== 4'hF) begin n_bad++; $display("FAIL reset_cmovl_dst: got %h want f", oDstE); end
    icode = 4'h1; #2;
    rst_n = 1'b1;
    m_cc = 3'b100;
  endtask

  task automatic test_add_overflow;
    logic [63:0] e;
    tick;
    set_op(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); #1;
    e = ref_valE(icode, ifun, valA, valB, valC);
    n_cmp++; if (valE !== e) begin n_bad++; $display("FAIL add_ovf_val: got %h want %h", valE, e); end
    m_cc = ref_cc(ifun, valA, valB, e);
    tick; icode = 4'h1; #1;
    n_cmp++; if (u_dut64.r_cc !== m_cc) begin n_bad++; $display("FAIL add_ovf_cc: got %b want %b", u_dut64.r_cc, m_cc); end
  endtask

  task automatic test_sub_cond;
    logic [63:0] e;
    tick;
    set_op(4'h6, 4'h1, 64'd5, 64'd5); #1;
    e = ref_valE(icode, ifun, valA, valB, valC);
    n_cmp++; if (valE !== e) begin n_bad++; $display("FAIL sub_val: got %h want %h", valE, e); end
    m_cc = ref_cc(ifun, valA, valB, e);
    tick; set_op(4'h2, 4'h1, 64'd9, 64'd0); dstE = 4'h4; #1;
    n_cmp++; if (u_dut64.r_cc !== m_cc) begin n_bad++; $display("FAIL sub_cc: got %b want %b", u_dut64.r_cc, m_cc); end
    n_cmp++; if (cnd !== ref_cnd(ifun, m_cc)) begin n_bad++; $display("FAIL cmovle_cnd: got %b want %b", cnd, ref_cnd(ifun, m_cc)); end
    ifun = 4'h2; #1;
    n_cmp++; if (cnd !== ref_cnd(ifun, m_cc)) begin n_bad++; $display("FAIL cmovl_cnd: got %b want %b", cnd, ref_cnd(ifun, m_cc)); end
    n_cmp++; if (oDstE !== 4'hF) begin n_bad++; $display("FAIL cmovl_dst: got %h want f", oDstE); end
  endtask

  task automatic test_random_alu;
    logic [3:0] ics [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    logic [63:0] e;
    logic        exc, ec;
    logic [3:0]  ed;
    for (int i = 0; i < 80; i++) begin
      tick;
      icode = (i % 12 == 11) ? 4'hB : ics[$urandom_range(0, 10)];
      ifun  = (icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 6));
      valA  = {$urandom, $urandom}; valB = {$urandom, $urandom}; valC = {$urandom, $urandom};
      if (i % 5 == 0) valB = valA;
      dstE  = 4'($urandom_range(0, 14)); dstM = 4'($urandom_range(0, 15));
      m_stat = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      #1;
      exc = (m_stat != 3'd1) || (W_stat != 3'd1);
      e   = ref_valE(icode, ifun, valA, valB, valC);
      ec  = ref_cnd(ifun, m_cc);
      ed  = (icode == 4'h2 && !ec) ? 4'hF : dstE;
      n_cmp++; if (valE !== e) begin n_bad++; $display("FAIL rnd_val[%0d]: got %h want %h", i, valE, e); end
      n_cmp++; if (cnd !== ec) begin n_bad++; $display("FAIL rnd_cnd[%0d]: got %b want %b", i, cnd, ec); end
      n_cmp++; if (oDstE !== ed) begin n_bad++; $display("FAIL rnd_dstE[%0d]: got %h want %h", i, oDstE, ed); end
      n_cmp++; if (oDstM !== dstM) begin n_bad++; $display("FAIL rnd_dstM[%0d]: got %h want %h", i, oDstM, dstM); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %b want 0", i, stall); end
      if (icode == 4'h6 && !exc) m_cc = ref_cc(ifun, valA, valB, e);
    end
    tick; icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1; #1;
    n_cmp++; if (u_dut64.r_cc !== m_cc) begin n_bad++; $display("FAIL rnd_cc: got %b want %b", u_dut64.r_cc, m_cc); end
  endtask

  task automatic test_mul;
    logic [63:0] e;
    int n;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 0) set_op(4'h6, 4'h4, 64'd7, 64'd6);
      else set_op(4'h6, 4'h4, {$urandom, $urandom}, {$urandom, $urandom});
      #1;
      e = ref_valE(icode, ifun, valA, valB, valC);
      n = 0;
      while (stall === 1'b1 && n < 200) begin
        if (n == 30) begin
          n_cmp++; if (u_dut64.r_cc !== m_cc) begin n_bad++; $display("FAIL mul_cc_hold[%0d]: got %b want %b", k, u_dut64.r_cc, m_cc); end
        end
        n++; tick;
      end
      n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL mul_stall_len[%0d]: got %0d want 65", k, n); end
      n_cmp++; if (valE !== e) begin n_bad++; $display("FAIL mul_val[%0d]: got %h want %h", k, valE, e); end
      m_cc = ref_cc(4'h4, valA, valB, e);
      tick; icode = 4'h1; #1;
      n_cmp++; if (u_dut64.r_cc !== m_cc) begin n_bad++; $display("FAIL mul_cc[%0d]: got %b want %b", k, u_dut64.r_cc, m_cc); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    int n;
    tick;
    set_op(4'h6, 4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2); #1;
    e = ref_valE(icode, ifun, valA, valB, valC);
    n = 0;
    while (stall === 1'b1 && n < 200) begin n++; tick; end
    n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL b2b_len1: got %0d want 65", n); end
    n_cmp++; if (valE !== e) begin n_bad++; $display("FAIL b2b_val1: got %h want %h", valE, e); end
    m_cc = ref_cc(4'h4, valA, valB, e);
    tick;
    set_op(4'h6, 4'h4, 64'd3, 64'd3); #1;
    n_cmp++; if (u_dut64.r_cc !== m_cc) begin n_bad++; $display("FAIL b2b_cc1: got %b want %b", u_dut64.r_cc, m_cc); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_issue: got %b want 1", stall); end
    e = ref_valE(icode, ifun, valA, valB, valC);
    n = 0;
    while (stall === 1'b1 && n < 200) begin n++; tick; end
    n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL b2b_len2: got %0d want 65", n); end
    n_cmp++; if (valE !== e) begin n_bad++; $display("FAIL b2b_val2: got %h want %h", valE, e); end
    m_cc = ref_cc(4'h4, valA, valB, e);
    tick; icode = 4'h1; #1;
    n_cmp++; if (u_dut64.r_cc !== m_cc) begin n_bad++; $display("FAIL b2b_cc2: got %b want %b", u_dut64.r_cc, m_cc); end
  endtask

  task automatic test_mul_abort;
    logic [63:0] e;
    int n;
    tick;
    set_op(4'h6, 4'h1, 64'd9, 64'd2); #1;
    m_cc = ref_cc(ifun, valA, valB, ref_valE(icode, ifun, valA, valB, valC));
    tick;
    set_op(4'h6, 4'h4, 64'd7, 64'd6);
    repeat (10) tick;
    m_stat = 3'd2; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL abort_stall: got %b want 0", stall); end
    tick; m_stat = 3'd1; icode = 4'h1; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %b want 0", stall); end
    n_cmp++; if (u_dut64.r_cc !== m_cc) begin n_bad++; $display("FAIL abort_cc: got %b want %b", u_dut64.r_cc, m_cc); end
    tick;
    set_op(4'h6, 4'h4, 64'd3, 64'd5); #1;
    e = ref_valE(icode, ifun, valA, valB, valC);
    n = 0;
    while (stall === 1'b1 && n < 200) begin n++; tick; end
    n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL abort_restart_len: got %0d want 65", n); end
    n_cmp++; if (valE !== e) begin n_bad++; $display("FAIL abort_restart_val: got %h want %h", valE, e); end
    m_cc = ref_cc(4'h4, valA, valB, e);
    tick; icode = 4'h1; #1;
  endtask

  task automatic test_reset_mid_mul;
    tick;
    set_op(4'h6, 4'h4, 64'd7, 64'd6);
    repeat (5) tick;
    #2;
    rst_n = 1'b0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
    n_cmp++; if (u_dut64.r_cc !== 3'b100) begin n_bad++; $display("FAIL rst_mid_cc: got %b want 100", u_dut64.r_cc); end
    m_cc = 3'b100;
    icode = 4'h1; #2;
    rst_n = 1'b1;
    tick; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after: got %b want 0", stall); end
  endtask

  task automatic test_xlen16;
    logic [15:0] e;
    int n;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (k == 0) set_op(4'h6, 4'h4, 64'd7, 64'd6);
      else set_op(4'h6, 4'h4, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)));
      #1;
      e = 16'(valA[15:0] * valB[15:0]);
      n = 0;
      while (stall16 === 1'b1 && n < 100) begin n++; tick; end
      n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL x16_len[%0d]: got %0d want 17", k, n); end
      n_cmp++; if (valE16 !== e) begin n_bad++; $display("FAIL x16_val[%0d]: got %h want %h", k, valE16, e); end
      tick; icode = 4'h1;
      tick;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add_overflow;
    test_sub_cond;
    test_random_alu;
    test_mul;
    test_back_to_back;
    test_mul_abort;
    test_reset_mid_mul;
    test_xlen16;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
